tow_rope_ctrl: RTL and testbench

//  Downstream consumer of the per-player push edge-detector pulses in the Tug-of-War game.

---
 rtl/tow_rope_ctrl_if.sv | 25 ++
 rtl/tow_rope_ctrl.sv | 116 +++++++++++
 tb/tb_tow_rope_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tow_rope_ctrl_if.sv
// rtl/tow_rope_ctrl_if.sv - referee/player pulses in, rope display and scores out
interface tow_rope_ctrl_if #(
    parameter int NUM_LEDS = 9,
    parameter int SCORE_W  = 4
);
    logic                start;
    logic                left_pull;
    logic                right_pull;
    logic [NUM_LEDS-1:0] leds;
    logic                go_led;
    logic                winner_left;
    logic                winner_right;
    logic [SCORE_W-1:0]  left_score;
    logic [SCORE_W-1:0]  right_score;

    modport master (
        output start, left_pull, right_pull,
        input  leds, go_led, winner_left, winner_right, left_score, right_score
    );

    modport slave (
        input  start, left_pull, right_pull,
        output leds, go_led, winner_left, winner_right, left_score, right_score
    );
endinterface

// File: rtl/tow_rope_ctrl.sv
// rtl/tow_rope_ctrl.sv - tug-of-war referee FSM, rope marker and saturating round scores
module tow_rope_ctrl #(
    parameter int NUM_LEDS = 9,
    parameter int GO_DELAY = 16,
    parameter int SCORE_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    tow_rope_ctrl_if.slave  rope
);
    localparam int POS_W = $clog2(NUM_LEDS);
    localparam int CNT_W = $clog2(GO_DELAY + 1);

    localparam logic [POS_W-1:0]   POS_C     = POS_W'((NUM_LEDS - 1) / 2);
    localparam logic [POS_W-1:0]   POS_L     = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]   POS_R     = '0;
    localparam logic [CNT_W-1:0]   CNT_GO    = CNT_W'(GO_DELAY - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PLAY,
        S_WIN_L,
        S_WIN_R
    } state_t;

    state_t              state, state_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [SCORE_W-1:0]  ls, ls_n;
    logic [SCORE_W-1:0]  rs, rs_n;
    logic [NUM_LEDS-1:0] leds_q;
    logic                step_up, step_dn, win_chk;

    always_comb begin
        state_n = state;
        pos_n   = pos;
        cnt_n   = cnt;
        ls_n    = ls;
        rs_n    = rs;
        step_up = 1'b0;
        step_dn = 1'b0;
        win_chk = 1'b0;

        case (state)
            S_IDLE: begin
                if (rope.start) begin
                    state_n = S_WAIT;
                    pos_n   = POS_C;
                    cnt_n   = '0;
                end
            end
            S_WAIT: begin
                // Early pulls are fouls: the marker moves against the offending player.
                cnt_n   = cnt + 1'b1;
                win_chk = 1'b1;
                step_dn = rope.left_pull & ~rope.right_pull;
                step_up = rope.right_pull & ~rope.left_pull;
                if (cnt == CNT_GO) state_n = S_PLAY;
            end
            S_PLAY: begin
                win_chk = 1'b1;
                step_up = rope.left_pull & ~rope.right_pull;
                step_dn = rope.right_pull & ~rope.left_pull;
            end
            S_WIN_L, S_WIN_R: begin
                if (rope.start) begin
                    state_n = S_WAIT;
                    pos_n   = POS_C;
                    cnt_n   = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (step_up && pos != POS_L) pos_n = pos + 1'b1;
        if (step_dn && pos != POS_R) pos_n = pos - 1'b1;

        // Reaching an end overrides the countdown expiring in the same cycle.
        if (win_chk) begin
            if (pos_n == POS_L) begin
                state_n = S_WIN_L;
                if (ls != SCORE_MAX) ls_n = ls + 1'b1;
            end else if (pos_n == POS_R) begin
                state_n = S_WIN_R;
                if (rs != SCORE_MAX) rs_n = rs + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pos    <= POS_C;
            cnt    <= '0;
            ls     <= '0;
            rs     <= '0;
            leds_q <= NUM_LEDS'(1) << POS_C;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            cnt    <= cnt_n;
            ls     <= ls_n;
            rs     <= rs_n;
            leds_q <= NUM_LEDS'(1) << pos_n;
        end
    end

    assign rope.leds         = leds_q;
    assign rope.go_led       = (state == S_PLAY);
    assign rope.winner_left  = (state == S_WIN_L);
    assign rope.winner_right = (state == S_WIN_R);
    assign rope.left_score   = ls;
    assign rope.right_score  = rs;
endmodule

// File: tb/tb_tow_rope_ctrl.sv
// tb/tb_tow_rope_ctrl.sv - directed bench for tow_rope_ctrl with NUM_LEDS=7, GO_DELAY=4, SCORE_W=2
module tb_tow_rope_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    tow_rope_ctrl_if #(.NUM_LEDS(7), .SCORE_W(2)) bus ();

    tow_rope_ctrl #(.NUM_LEDS(7), .GO_DELAY(4), .SCORE_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .rope (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one cycle of inputs, returns at the following negedge.
    task automatic cyc(input logic s, input logic l, input logic r);
        bus.start      = s;
        bus.left_pull  = l;
        bus.right_pull = r;
        @(posedge clk);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.left_pull  = 1'b0;
        bus.right_pull = 1'b0;
    endtask

    task automatic left_round(input logic [31:0] exp_ls);
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);
        repeat (3) cyc(0, 1, 0);
        chk("lw_winner", bus.winner_left, 1);
        chk("lw_score", bus.left_score, exp_ls);
        chk("lw_leds", bus.leds, 7'b1000000);
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.left_pull  = 1'b0;
        bus.right_pull = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_leds", bus.leds, 7'b0001000);
        chk("rst_go", bus.go_led, 0);
        chk("rst_win", {bus.winner_left, bus.winner_right}, 0);
        chk("rst_scores", {bus.left_score, bus.right_score}, 0);
        rst = 1'b0;

        cyc(0, 1, 0);
        chk("idle_pull", bus.leds, 7'b0001000);
        cyc(1, 0, 0);
        chk("start_leds", bus.leds, 7'b0001000);
        chk("start_go", bus.go_led, 0);
        repeat (3) cyc(0, 0, 0);
        chk("wait3_go", bus.go_led, 0);
        cyc(0, 0, 0);
        chk("wait4_go", bus.go_led, 1);

        cyc(0, 1, 0);
        chk("play_l1", bus.leds, 7'b0010000);
        cyc(0, 1, 0);
        chk("play_l2", bus.leds, 7'b0100000);
        cyc(0, 1, 0);
        chk("play_l3", bus.leds, 7'b1000000);
        chk("winl_flag", bus.winner_left, 1);
        chk("winl_score", bus.left_score, 1);
        chk("winl_go", bus.go_led, 0);
        cyc(0, 0, 1);
        chk("winl_frozen", bus.leds, 7'b1000000);

        cyc(1, 0, 0);
        chk("restart_leds", bus.leds, 7'b0001000);
        chk("restart_flag", bus.winner_left, 0);
        cyc(0, 0, 1);
        chk("foul_r", bus.leds, 7'b0010000);
        repeat (2) cyc(0, 0, 0);
        chk("foul_go_early", bus.go_led, 0);
        cyc(0, 0, 0);
        chk("foul_go_sched", bus.go_led, 1);
        chk("foul_hold", bus.leds, 7'b0010000);

        cyc(0, 1, 1);
        chk("both_hold", bus.leds, 7'b0010000);
        cyc(1, 0, 0);
        chk("play_start_go", bus.go_led, 1);
        chk("play_start_leds", bus.leds, 7'b0010000);
        repeat (3) cyc(0, 0, 1);
        chk("play_r3", bus.leds, 7'b0000010);
        chk("play_r3_flag", bus.winner_right, 0);
        cyc(0, 0, 1);
        chk("winr_leds", bus.leds, 7'b0000001);
        chk("winr_flag", bus.winner_right, 1);
        chk("winr_score", bus.right_score, 1);
        chk("winr_go", bus.go_led, 0);

        left_round(2);
        left_round(3);
        left_round(3);
        cyc(1, 0, 0);
        chk("sat_restart_leds", bus.leds, 7'b0001000);
        chk("sat_restart_flag", bus.winner_left, 0);

        // Foul-driven right win lands on the very cycle the countdown expires.
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("foul_l2", bus.leds, 7'b0000010);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("prio_go", bus.go_led, 0);
        chk("prio_winr", bus.winner_right, 1);
        chk("prio_score", bus.right_score, 2);
        chk("prio_leds", bus.leds, 7'b0000001);

        cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        chk("foulwin_score", bus.right_score, 3);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        chk("rsat_score", bus.right_score, 3);
        chk("rsat_flag", bus.winner_right, 1);

        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);
        repeat (2) cyc(0, 1, 0);
        chk("pre_rst_leds", bus.leds, 7'b0100000);
        rst = 1'b1;
        #1;
        chk("arst_leds", bus.leds, 7'b0001000);
        chk("arst_scores", {bus.left_score, bus.right_score}, 0);
        chk("arst_go", bus.go_led, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 0);
        chk("post_rst_idle", bus.leds, 7'b0001000);
        chk("post_rst_go", bus.go_led, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
